servo_ramp: RTL

SERVO_RAMP -- requirements
Module: servo_ramp

---
 rtl/servo_pkg.sv | 12 +
 rtl/ramp_tick.sv | 29 ++
 rtl/servo_ramp.sv | 137 +++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared types and default width for the servo ramp slice.
package servo_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ramp_tick.sv
// ramp_tick: free-running step-rate divider shared by all servo channels.
// Counts 0..TICK_DIV-1 while enabled and pulses tick on the last count.
module ramp_tick #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  TC    = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Divider count: cleared on reset or a new transfer, wraps at the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == TC) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == TC);

endmodule

// File: rtl/servo_ramp.sv
// servo_ramp: rate-limited ramp of three servo positions toward a latched
// target triple. Optional build macro SERVO_RAMP_LIMIT_EN clamps accepted
// targets to [POS_MIN, POS_MAX].
//
// state | meaning
// IDLE  | holding positions, ready to accept a target triple
// RAMP  | stepping positions toward targets once per tick
// DONE  | one-cycle completion pulse, positions held
module servo_ramp
  import servo_pkg::*;
#(
  parameter int DATA_WIDTH = servo_pkg::DATA_WIDTH,
  parameter int TICK_DIV   = 500000,
  parameter int STEP       = 1,
  parameter int RESET_POS  = 128,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tgt_x,
  input  logic [DATA_WIDTH-1:0] tgt_y,
  input  logic [DATA_WIDTH-1:0] tgt_z,
  input  logic                  tgt_valid,
  output logic                  tgt_ready,
  output logic [DATA_WIDTH-1:0] pos_x,
  output logic [DATA_WIDTH-1:0] pos_y,
  output logic [DATA_WIDTH-1:0] pos_z,
  output logic                  busy,
  output logic                  done
);

  // Step size saturated to the bus width so the compare below never truncates.
  localparam logic [DATA_WIDTH-1:0] STEP_W =
    (STEP > (2**DATA_WIDTH) - 1) ? {DATA_WIDTH{1'b1}} : DATA_WIDTH'(STEP);
  localparam logic [DATA_WIDTH-1:0] RST_W = DATA_WIDTH'(RESET_POS);

  // Elaboration-time parameter sanity checks.
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("servo_ramp: TICK_DIV must be 2 or greater");
  end
  if (STEP < 1) begin : g_bad_step
    $error("servo_ramp: STEP must be 1 or greater");
  end
  if (POS_MIN > POS_MAX) begin : g_bad_limits
    $error("servo_ramp: POS_MIN must not exceed POS_MAX");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pos_x, r_pos_y, r_pos_z;
  logic [DATA_WIDTH-1:0] r_tgt_x, r_tgt_y, r_tgt_z;
  logic                  w_xfer;
  logic                  w_tick;
  logic                  w_at_tgt;

  // Move one step toward the target without overshoot; unsigned, never wraps.
  function automatic logic [DATA_WIDTH-1:0] step_toward(
    input logic [DATA_WIDTH-1:0] pos,
    input logic [DATA_WIDTH-1:0] tgt
  );
    if (pos < tgt) begin
      return ((tgt - pos) <= STEP_W) ? tgt : pos + STEP_W;
    end else if (pos > tgt) begin
      return ((pos - tgt) <= STEP_W) ? tgt : pos - STEP_W;
    end
    return pos;
  endfunction

`ifdef SERVO_RAMP_LIMIT_EN
  function automatic logic [DATA_WIDTH-1:0] limit(input logic [DATA_WIDTH-1:0] v);
    if (v < DATA_WIDTH'(POS_MIN)) return DATA_WIDTH'(POS_MIN);
    if (v > DATA_WIDTH'(POS_MAX)) return DATA_WIDTH'(POS_MAX);
    return v;
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] limit(input logic [DATA_WIDTH-1:0] v);
    return v;
  endfunction
`endif

  assign tgt_ready = (r_state == IDLE) && !rst;
  assign w_xfer    = tgt_valid && tgt_ready;
  assign w_at_tgt  = (r_pos_x == r_tgt_x) && (r_pos_y == r_tgt_y) && (r_pos_z == r_tgt_z);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign pos_z     = r_pos_z;

  ramp_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (w_xfer),
    .en  (r_state == RAMP),
    .tick(w_tick)
  );

  // Next-state: completion is checked every cycle, not only on ticks.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_xfer)   w_state_nxt = RAMP;
      RAMP:    if (w_at_tgt) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, target latch and per-tick position update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pos_x <= RST_W;
      r_pos_y <= RST_W;
      r_pos_z <= RST_W;
      r_tgt_x <= RST_W;
      r_tgt_y <= RST_W;
      r_tgt_z <= RST_W;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_tgt_x <= limit(tgt_x);
        r_tgt_y <= limit(tgt_y);
        r_tgt_z <= limit(tgt_z);
      end
      if ((r_state == RAMP) && w_tick) begin
        r_pos_x <= step_toward(r_pos_x, r_tgt_x);
        r_pos_y <= step_toward(r_pos_y, r_tgt_y);
        r_pos_z <= step_toward(r_pos_z, r_tgt_z);
      end
    end
  end

endmodule
